// File: rtl/xcore_ram_ctrl.sv
// xcore_ram_ctrl: adapts a valid/ready command/response bus (byte address,
// byte write mask) onto the strobes of a single-port SRAM with a fixed
// one-cycle read latency. Only one transaction is in flight at a time.
// Out-of-range addresses are answered with an error and never reach the RAM.
// If the response is stalled, the read data is parked locally so the RAM
// output is free to change.
module xcore_ram_ctrl #(
    parameter int DP  = 1024,
    parameter int DW  = 32,
    parameter int MW  = 4,
    parameter int AW  = 10,
    parameter int BW  = 2,
    parameter int CAW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_read,
    input  logic [CAW-1:0] cmd_addr,
    input  logic [DW-1:0]  cmd_wdata,
    input  logic [MW-1:0]  cmd_wmask,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_rdata,
    output logic           rsp_err,
    output logic           ram_cs,
    output logic           ram_wen,
    output logic [MW-1:0]  ram_wem,
    output logic [AW-1:0]  ram_addr,
    output logic [DW-1:0]  ram_din,
    input  logic [DW-1:0]  ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } state_t;

    // Word count as an AW+1 bit value so that DP == 2**AW still fits.
    localparam logic [AW:0] DP_LIM = (AW+1)'(DP);

    state_t        state;
    logic          init_done;
    logic          rd_r;
    logic [DW-1:0] hold_r;
    logic          acc;
    logic          err;
    logic          hi_err;
    logic          idx_err;
    logic [AW-1:0] word_idx;
    logic          unused_low_addr;

    // The byte-offset bits carry no meaning here because accesses are word wide.
    assign unused_low_addr = ^cmd_addr[BW-1:0];

    assign word_idx = cmd_addr[AW+BW-1:BW];

    // Any address bit above the word index makes the access out of range.
    generate
        if (CAW > AW + BW) begin : g_hi_bits
            assign hi_err = |cmd_addr[CAW-1:AW+BW];
        end else begin : g_no_hi_bits
            assign hi_err = 1'b0;
        end
    endgenerate

    assign idx_err = ({1'b0, word_idx} >= DP_LIM);
    assign err     = hi_err | idx_err;

    // A new command may be taken when nothing is pending or when the pending
    // response is being consumed in this same cycle.
    assign cmd_ready = init_done & ((state == IDLE) | rsp_ready);
    assign acc       = cmd_valid & cmd_ready;

    // The RAM is strobed in the accept cycle itself. Error commands are kept off the RAM.
    assign ram_cs   = acc & ~err;
    assign ram_wen  = ~cmd_read;
    assign ram_wem  = cmd_read ? '0 : cmd_wmask;
    assign ram_addr = word_idx;
    assign ram_din  = cmd_wdata;

    // Response data: live RAM output in the first response cycle, parked copy once stalled.
    always_comb begin
        rsp_rdata = '0;
        if (state == HOLD) begin
            rsp_rdata = hold_r;
        end else if ((state == RESP) && rd_r) begin
            rsp_rdata = ram_dout;
        end
    end

    // Transaction state machine, including the response flags and the stall buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_r      <= 1'b0;
            hold_r    <= '0;
        end else begin
            init_done <= 1'b1;
            if (acc) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rd_r      <= cmd_read & ~err;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RESP: begin
                        if (rsp_ready) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_err   <= 1'b0;
                            rd_r      <= 1'b0;
                        end else begin
                            state  <= HOLD;
                            hold_r <= rsp_rdata;
                        end
                    end
                    HOLD: begin
                        if (rsp_ready) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            rsp_err   <= 1'b0;
                            rd_r      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rd_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xcore_ram_ctrl.sv
// tb_xcore_ram_ctrl: directed and randomized bench for xcore_ram_ctrl.
// A behavioural RAM sits on the RAM port. Expected responses come from a
// transaction-level shadow memory that is updated at each accepted write.
module tb_xcore_ram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_cs;
    logic        ram_wen;
    logic [3:0]  ram_wem;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] ram_mem [0:1023];
    logic [31:0] ram_q;
    logic [31:0] force_val;
    logic        force_en;

    logic [31:0] model_mem [int unsigned];

    int checks = 0;
    int errors = 0;

    xcore_ram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wmask (cmd_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_cs    (ram_cs),
        .ram_wen   (ram_wen),
        .ram_wem   (ram_wem),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bench can override the RAM output to show that a stalled response ignores it.
    assign ram_dout = force_en ? force_val : ram_q;

    // Behavioural single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_q <= ram_mem[ram_addr];
            end
        end
    end

    function automatic logic [31:0] model_read(input int unsigned idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return 32'h0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete transaction: issue, check RAM strobes, check response, optional stall.
    task automatic applyStimulus(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] mask, input int stall, output logic [31:0] got);
        logic        exp_err;
        logic [31:0] exp_data;
        logic [31:0] bmask;
        int unsigned widx;
        int          waits;
        exp_err  = (addr >= 32'h0000_1000);
        widx     = addr / 4;
        exp_data = (!exp_err && rd) ? model_read(widx) : 32'h0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wmask = mask;
        rsp_ready = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        #1;
        checkOutput("cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("ram_cs", 32'(ram_cs), 32'(!exp_err));
        checkOutput("ram_wen", 32'(ram_wen), 32'(!rd));
        checkOutput("ram_wem", 32'(ram_wem), rd ? 32'd0 : 32'(mask));
        if (!exp_err) checkOutput("ram_addr", 32'(ram_addr), 32'(widx));
        @(posedge clk);
        if (!exp_err && !rd) begin
            bmask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
            model_mem[widx] = (model_read(widx) & ~bmask) | (wdata & bmask);
        end
        #1;
        cmd_valid = 1'b0;
        got = rsp_rdata;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        checkOutput("rsp_rdata", rsp_rdata, exp_data);
        if (stall > 0) begin
            rsp_ready = 1'b0;
            #1;
            checkOutput("stall_ready0", 32'(cmd_ready), 32'd0);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                force_val = $urandom;
                force_en  = 1'b1;
                #1;
                checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
                checkOutput("stall_rdata", rsp_rdata, exp_data);
                checkOutput("stall_err", 32'(rsp_err), 32'(exp_err));
                checkOutput("stall_ready", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        force_en = 1'b0;
        checkOutput("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    // Directed test plan followed by randomized traffic and a reset-in-stall check
    initial begin
        logic [31:0] got;
        logic [31:0] ra;
        int          sel;

        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
        ram_q     = 32'h0;
        force_val = 32'h0;
        force_en  = 1'b0;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wmask = 4'h0;
        rsp_ready = 1'b1;

        #12;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset_ram_cs", 32'(ram_cs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("release_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("release_ram_cs", 32'(ram_cs), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checkOutput("init_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("init_rsp_valid", 32'(rsp_valid), 32'd0);

        applyStimulus(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, got);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'h0, 0, got);
        checkOutput("plan_full_read", got, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h10, 32'h0000_AB00, 4'b0010, 0, got);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'h0, 0, got);
        checkOutput("plan_partial_read", got, 32'hDEAD_ABEF);
        applyStimulus(1'b0, 32'h10, 32'h1234_5678, 4'h0, 0, got);
        applyStimulus(1'b1, 32'h10, 32'h0, 4'h0, 5, got);
        checkOutput("plan_stall_read", got, 32'hDEAD_ABEF);
        applyStimulus(1'b1, 32'h0000_1000, 32'h0, 4'h0, 0, got);
        applyStimulus(1'b1, 32'h8000_0000, 32'h0, 4'h0, 2, got);
        applyStimulus(1'b0, 32'h0000_1FFC, 32'hFFFF_FFFF, 4'hF, 0, got);

        applyStimulus(1'b0, 32'h0, 32'h1111_1111, 4'hF, 0, got);
        applyStimulus(1'b0, 32'h4, 32'h2222_2222, 4'hF, 0, got);
        applyStimulus(1'b0, 32'h8, 32'h3333_3333, 4'hF, 0, got);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("b2b_ram_cs", 32'(ram_cs), 32'd1);
            @(posedge clk);
            #1;
            checkOutput("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("b2b_rsp_rdata", rsp_rdata, model_read(k));
            if (k < 2) cmd_addr = 32'(4 * (k + 1));
            else cmd_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("b2b_idle", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) ra = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else if (sel == 1) ra = $urandom | 32'h8000_0000;
            else ra = $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), $urandom_range(0, 3), got);
        end

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = 1'b1;
        cmd_addr  = 32'h10;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("hold_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("hold_reset_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        checkOutput("rerelease_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("reinit_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reinit_rsp_valid", 32'(rsp_valid), 32'd0);

        applyStimulus(1'b1, 32'h10, 32'h0, 4'h0, 1, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xcore_ram_ctrl.md
Name: xcore_ram_ctrl

Overview:
- Bus-to-SRAM adapter that sits directly upstream of the core's single-port simulation/synthesis RAM.
- Converts a valid/ready command/response bus (byte address, write mask) into the RAM's cs/wen/wem/addr/din strobes.
- Absorbs the RAM's fixed 1-cycle read latency and stalls on response back-pressure without losing read data.
- One outstanding transaction. Out-of-range accesses return an error response instead of reaching the RAM.

Parameters:
- DP, 1024, RAM depth in words.
- DW, 32, data width; must be a multiple of 8.
- MW, 4, byte-mask width; equals DW/8.
- AW, 10, RAM word-address width; ceil(log2(DP)).
- BW, 2, byte-offset bits; log2(MW).
- CAW, 32, command byte-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  CAW  byte address.
- cmd_wdata  in  DW  write data.
- cmd_wmask  in  MW  byte write enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  access was out of range.
- ram_cs  out  1  RAM chip select.
- ram_wen  out  1  RAM write enable.
- ram_wem  out  MW  RAM byte mask.
- ram_addr  out  AW  RAM word address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data, valid the cycle after a read strobe.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - State = IDLE.
  - rsp_valid=0, rsp_err=0, hold_r=0.
  - Flag init_done=0, which forces cmd_ready=0 and ram_cs=0.
  - init_done sets at the first posedge after rst_n rises, so cmd_ready can first be 1 one cycle after release.
- Accept: acc = cmd_valid & cmd_ready.
- Ready rule: cmd_ready = init_done & (state==IDLE | rsp_ready). This gives back-to-back accepts with zero bubbles when rsp_ready=1.
- Range check:
  - err = |cmd_addr[CAW-1:AW+BW], or word index cmd_addr[AW+BW-1:BW] >= DP.
  - Low BW address bits are ignored; there is no misalignment error.
- RAM drive (combinational, same cycle as acc):
  - ram_cs = acc & ~err.
  - ram_wen = ~cmd_read.
  - ram_wem = cmd_read ? 0 : cmd_wmask.
  - ram_addr = word index.
  - ram_din = cmd_wdata.
  - Error commands never strobe the RAM.
- Pending-type regs: rd_r = cmd_read & ~err and err_r = err, both captured on acc.
- State machine:
  - IDLE: on acc -> RESP.
  - RESP:
    - rsp_valid=1, rsp_err=err_r, rsp_rdata = rd_r ? ram_dout : 0.
    - If rsp_ready & acc -> RESP (new transaction).
    - If rsp_ready & ~acc -> IDLE.
    - If ~rsp_ready -> HOLD, capturing hold_r <= rsp_rdata.
  - HOLD:
    - rsp_valid=1, rsp_rdata=hold_r.
    - rsp_ready & acc -> RESP; rsp_ready & ~acc -> IDLE; else stay in HOLD.
- Stall guarantee: rsp_rdata/rsp_err remain stable from the first rsp_valid cycle until the handshake, even if the RAM output changes.
- Latency: response appears exactly 1 cycle after acceptance when not back-pressured. Throughput is 1 transaction/cycle.
- Write with all-zero mask: RAM is strobed with wem=0 (no change), normal response, rsp_err=0.
- Reset mid-transaction: the pending response is dropped; rsp_valid falls immediately (asynchronously).

Test Plan:
- Reset, then write 0xDEADBEEF to byte addr 0x10 with mask 4'hF:
  - ram_cs=1, ram_wen=1, ram_addr=4 in the accept cycle.
  - rsp_valid the next cycle with rdata=0, err=0.
- Read 0x10 after that write:
  - ram_cs=1, ram_wen=0, ram_addr=4.
  - Next cycle rsp_rdata=0xDEADBEEF, rsp_err=0.
- Partial write mask 4'b0010 with data 0x0000AB00 to 0x10, then read:
  - rsp_rdata=0xDEADABEF.
- Read 0x10 with rsp_ready=0 for 5 cycles, while the bench forces ram_dout to change:
  - rsp_rdata holds 0xDEADABEF.
  - cmd_ready=0 throughout.
  - Handshake completes when rsp_ready=1; state returns to IDLE.
- Read byte addr 0x1000 (word 1024 >= DP), and separately addr 0x8000_0000:
  - ram_cs=0 in both cases.
  - rsp_err=1, rsp_rdata=0.
- Reset behaviour:
  - Back-to-back reads of 0x0, 0x4, 0x8 with rsp_ready=1 produce 3 responses on 3 consecutive cycles with no bubble.
  - Asserting rst_n=0 while in HOLD clears rsp_valid immediately.
  - cmd_ready stays 0 until the first posedge after release.
